// File: rtl/oci_debug_ram_ctrl.sv
// OCI debug RAM controller: serves JTAG monitor reads/writes from the debug slave and
// arbitrates them against the CPU's Avalon debug-memory port on a single-port RAM.
module oci_debug_ram_ctrl #(
  parameter int unsigned ADDR_W    = 8,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  input  logic              cpu_debugaccess,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              mon_busy,
  output logic              mon_overrun
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StJRd, StCRd} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] jaddr_q;
  logic              pending_q;
  logic              op_wr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mon_dreg_q;
  logic [31:0]       readdata_q;
  logic              overrun_q;

  logic [31:0]       mem [Depth];
  logic [31:0]       ram_q;
  logic              ram_we;
  logic              ram_re;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [ADDR_W-1:0] ram_addr;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  // RAM port steering; a pending JTAG command always beats a new CPU request in idle.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_be    = 4'h0;
    ram_wdata = '0;
    ram_addr  = jaddr_q;
    if (!reset && state_q == StIdle) begin
      if (pending_q) begin
        if (op_wr_q) begin
          ram_we    = 1'b1;
          ram_be    = 4'hf;
          ram_wdata = wdata_q;
        end else begin
          ram_re = 1'b1;
        end
      end else if (cpu_read) begin
        ram_addr = cpu_address;
        ram_re   = 1'b1;
      end else if (cpu_write && cpu_debugaccess) begin
        ram_addr  = cpu_address;
        ram_we    = 1'b1;
        ram_be    = cpu_byteenable;
        ram_wdata = cpu_writedata;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we && ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    if (ram_re) ram_q <= mem[ram_addr];
  end

  always_comb begin
    cpu_waitrequest = 1'b1;
    if (!reset) begin
      if (state_q == StCRd) begin
        cpu_waitrequest = 1'b0;
      end else if (state_q == StIdle && !pending_q && !cpu_read && cpu_write) begin
        cpu_waitrequest = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      jaddr_q    <= '0;
      pending_q  <= 1'b0;
      op_wr_q    <= 1'b0;
      wdata_q    <= '0;
      mon_dreg_q <= '0;
      readdata_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pending_q) begin
            if (op_wr_q) begin
              mon_dreg_q <= wdata_q;
              jaddr_q    <= jaddr_q + 1'b1;
              pending_q  <= 1'b0;
            end else begin
              state_q <= StJRd;
            end
          end else if (cpu_read) begin
            state_q <= StCRd;
          end
        end
        StJRd: begin
          mon_dreg_q <= ram_q;
          jaddr_q    <= jaddr_q + 1'b1;
          pending_q  <= 1'b0;
          state_q    <= StIdle;
        end
        StCRd: begin
          readdata_q <= ram_q;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // Strobes are only accepted with nothing pending, so they never collide with the
      // FSM's own updates of jaddr/pending above.
      if (take_action_ocimem_b) begin
        if (pending_q || take_action_ocimem_a || take_no_action_ocimem_a) overrun_q <= 1'b1;
        if (!pending_q) begin
          pending_q <= 1'b1;
          op_wr_q   <= 1'b1;
          wdata_q   <= jdo[34:3];
        end
      end else if (take_action_ocimem_a) begin
        if (pending_q || take_no_action_ocimem_a) overrun_q <= 1'b1;
        if (!pending_q) begin
          jaddr_q <= jdo[17 +: ADDR_W];
          if (jdo[35]) begin
            pending_q <= 1'b1;
            op_wr_q   <= 1'b0;
          end
        end
      end else if (take_no_action_ocimem_a) begin
        if (pending_q) begin
          overrun_q <= 1'b1;
        end else begin
          pending_q <= 1'b1;
          op_wr_q   <= 1'b0;
        end
      end
    end
  end

  assign cpu_readdata = (state_q == StCRd) ? ram_q : readdata_q;
  assign MonDReg      = mon_dreg_q;
  assign mon_busy     = pending_q | (state_q == StJRd);
  assign mon_overrun  = overrun_q;

endmodule

// File: tb/tb_oci_debug_ram_ctrl.sv
// Directed bench for oci_debug_ram_ctrl: JTAG access, address wrap, CPU access and arbitration.
module tb_oci_debug_ram_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [7:0]  cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic        cpu_debugaccess;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic [31:0] MonDReg;
  logic        mon_busy;
  logic        mon_overrun;

  int checks = 0;
  int errors = 0;

  oci_debug_ram_ctrl #(.ADDR_W(8), .INIT_FILE("")) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_writedata           (cpu_writedata),
    .cpu_byteenable          (cpu_byteenable),
    .cpu_debugaccess         (cpu_debugaccess),
    .cpu_readdata            (cpu_readdata),
    .cpu_waitrequest         (cpu_waitrequest),
    .MonDReg                 (MonDReg),
    .mon_busy                (mon_busy),
    .mon_overrun             (mon_overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_a(input logic [7:0] addr, input logic rd);
    jdo = '0;
    jdo[24:17] = addr;
    jdo[35] = rd;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic strobe_b(input logic [31:0] data);
    jdo = '0;
    jdo[34:3] = data;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic strobe_na();
    jdo = '0;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
  endtask

  // Full JTAG write: set address, queue write, let it be served.
  task automatic jtag_write(input logic [7:0] addr, input logic [31:0] data);
    strobe_a(addr, 1'b0);
    strobe_b(data);
    tick();
  endtask

  task automatic cpu_wr(input logic [7:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input logic dbg);
    cpu_address = addr;
    cpu_writedata = data;
    cpu_byteenable = be;
    cpu_debugaccess = dbg;
    cpu_write = 1'b1;
    #1;
    checks++;
    if (cpu_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL cpu_write_accept: waitrequest=%b required 0", cpu_waitrequest);
    end
    tick();
    cpu_write = 1'b0;
    cpu_debugaccess = 1'b0;
  endtask

  task automatic cpu_rd(input logic [7:0] addr, output logic [31:0] data, output int lat);
    cpu_address = addr;
    cpu_read = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (cpu_waitrequest && lat < 8);
    data = cpu_readdata;
    cpu_read = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({MonDReg, mon_busy, mon_overrun} !== 34'h0) begin
      errors++;
      $display("FAIL reset_mon: MonDReg=%h busy=%b ovr=%b required 0/0/0", MonDReg, mon_busy,
               mon_overrun);
    end
    checks++;
    if (cpu_readdata !== 32'h0 || cpu_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL reset_cpu: readdata=%h waitreq=%b required 0/1", cpu_readdata,
               cpu_waitrequest);
    end
  endtask

  task automatic test_jtag_write();
    strobe_a(8'h10, 1'b0);
    strobe_b(32'hCAFEF00D);
    checks++;
    if (mon_busy !== 1'b1) begin
      errors++;
      $display("FAIL jwr_busy: mon_busy=%b required 1", mon_busy);
    end
    tick();
    checks++;
    if (MonDReg !== 32'hCAFEF00D || mon_busy !== 1'b0) begin
      errors++;
      $display("FAIL jwr_done: MonDReg=%h busy=%b required cafef00d/0", MonDReg, mon_busy);
    end
    checks++;
    if (dut.jaddr_q !== 8'h11) begin
      errors++;
      $display("FAIL jwr_jaddr: jaddr=%h required 11", dut.jaddr_q);
    end
    strobe_b(32'h11112222);
    tick();
  endtask

  task automatic test_jtag_read();
    strobe_a(8'h10, 1'b1);
    tick();
    checks++;
    if (MonDReg !== 32'h11112222 || mon_busy !== 1'b1) begin
      errors++;
      $display("FAIL jrd_early: MonDReg=%h busy=%b required 11112222/1", MonDReg, mon_busy);
    end
    tick();
    checks++;
    if (MonDReg !== 32'hCAFEF00D || mon_busy !== 1'b0) begin
      errors++;
      $display("FAIL jrd_data: MonDReg=%h busy=%b required cafef00d/0", MonDReg, mon_busy);
    end
    strobe_na();
    tick();
    tick();
    checks++;
    if (MonDReg !== 32'h11112222 || dut.jaddr_q !== 8'h12) begin
      errors++;
      $display("FAIL jrd_noaction: MonDReg=%h jaddr=%h required 11112222/12", MonDReg,
               dut.jaddr_q);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    int lat;
    jtag_write(8'hFF, 32'h00000001);
    checks++;
    if (dut.jaddr_q !== 8'h00 || MonDReg !== 32'h1) begin
      errors++;
      $display("FAIL wrap_jaddr: jaddr=%h MonDReg=%h required 00/1", dut.jaddr_q, MonDReg);
    end
    cpu_rd(8'hFF, d, lat);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL wrap_ram: RAM[ff]=%h required 1", d);
    end
  endtask

  task automatic test_cpu_access();
    logic [31:0] d;
    int lat;
    jtag_write(8'h20, 32'hAAAABBBB);
    cpu_wr(8'h20, 32'h12345678, 4'b0011, 1'b1);
    cpu_rd(8'h20, d, lat);
    checks++;
    if (d !== 32'hAAAA5678) begin
      errors++;
      $display("FAIL cpu_be_write: readdata=%h required aaaa5678", d);
    end
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL cpu_rd_latency: cycles=%0d required 1", lat);
    end
    cpu_wr(8'h20, 32'h87654321, 4'b1111, 1'b0);
    cpu_rd(8'h20, d, lat);
    checks++;
    if (d !== 32'hAAAA5678) begin
      errors++;
      $display("FAIL cpu_nodebug_write: readdata=%h required aaaa5678", d);
    end
  endtask

  task automatic test_arbitration();
    strobe_a(8'h30, 1'b0);
    cpu_address = 8'h20;
    cpu_read = 1'b1;
    jdo = '0;
    jdo[34:3] = 32'h55AA55AA;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    checks++;
    if (cpu_waitrequest !== 1'b0 || cpu_readdata !== 32'hAAAA5678 || mon_busy !== 1'b1) begin
      errors++;
      $display("FAIL arb_cpu_first: waitreq=%b readdata=%h busy=%b required 0/aaaa5678/1",
               cpu_waitrequest, cpu_readdata, mon_busy);
    end
    cpu_read = 1'b0;
    tick();
    checks++;
    if (cpu_waitrequest !== 1'b1 || cpu_readdata !== 32'hAAAA5678) begin
      errors++;
      $display("FAIL arb_hold: waitreq=%b readdata=%h required 1/aaaa5678", cpu_waitrequest,
               cpu_readdata);
    end
    tick();
    checks++;
    if (MonDReg !== 32'h55AA55AA || mon_busy !== 1'b0 || mon_overrun !== 1'b0 ||
        dut.jaddr_q !== 8'h31) begin
      errors++;
      $display("FAIL arb_jtag_after: MonDReg=%h busy=%b ovr=%b jaddr=%h required 55aa55aa/0/0/31",
               MonDReg, mon_busy, mon_overrun, dut.jaddr_q);
    end
  endtask

  task automatic test_back_to_back();
    strobe_a(8'h40, 1'b0);
    strobe_b(32'h01010101);
    strobe_b(32'h02020202);
    checks++;
    if (mon_overrun !== 1'b1 || MonDReg !== 32'h01010101 || mon_busy !== 1'b0 ||
        dut.jaddr_q !== 8'h41) begin
      errors++;
      $display("FAIL b2b_drop: ovr=%b MonDReg=%h busy=%b jaddr=%h required 1/01010101/0/41",
               mon_overrun, MonDReg, mon_busy, dut.jaddr_q);
    end
    tick();
    tick();
    checks++;
    if (mon_overrun !== 1'b1) begin
      errors++;
      $display("FAIL b2b_sticky: ovr=%b required 1", mon_overrun);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] d;
    int lat;
    strobe_a(8'h40, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (MonDReg !== 32'h0 || mon_overrun !== 1'b0 || mon_busy !== 1'b0 ||
        dut.jaddr_q !== 8'h00) begin
      errors++;
      $display("FAIL rst_jrd: MonDReg=%h ovr=%b busy=%b jaddr=%h required 0/0/0/00", MonDReg,
               mon_overrun, mon_busy, dut.jaddr_q);
    end
    cpu_rd(8'h40, d, lat);
    checks++;
    if (d !== 32'h01010101 || lat != 1) begin
      errors++;
      $display("FAIL rst_ram_kept: readdata=%h lat=%0d required 01010101/1", d, lat);
    end
    // Queue a write, then reset in the cycle it would be served.
    jtag_write(8'h50, 32'h0BADF00D);
    strobe_a(8'h50, 1'b0);
    strobe_b(32'hDEADBEEF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cpu_rd(8'h50, d, lat);
    checks++;
    if (d !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL rst_no_write: RAM[50]=%h required 0badf00d", d);
    end
  endtask

  initial begin
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    cpu_address = '0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_writedata = '0;
    cpu_byteenable = '0;
    cpu_debugaccess = 1'b0;
    test_reset();
    test_jtag_write();
    test_jtag_read();
    test_wrap();
    test_cpu_access();
    test_arbitration();
    test_back_to_back();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
